// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte producers.
// Ready and DV are registered and arrive 1 cycle after capture; unaccepted bytes stay with their requester.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int START_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Err
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_ptr;
    logic               r_lock;
    logic               r_last;
    logic [SW-1:0]      r_start_tmr;
    logic [LW-1:0]      r_lock_tmr;
    logic [NUM_REQ-1:0] r_ready;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_dv;
    logic               r_err;
    logic [7:0]         r_byte;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW:0]        w_idx;
    logic [PW-1:0]      w_sel;
    logic [PW+2:0]      w_bit;
    logic               w_go;
    logic               w_lock_to;
    logic               w_start_to;
    logic [NUM_REQ-1:0] w_onehot;

    // First valid requester scanning upward from ptr+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (PW+1)'(r_ptr) + (PW+1)'(i);
            if (w_idx >= NR) begin
                w_idx = w_idx - NR;
            end
            if (!w_found && i_Req_Valid[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    // While locked, ptr already names the holder and only it may issue.
    assign w_sel      = r_lock ? r_ptr : w_win;
    assign w_bit      = {w_sel, 3'b000};
    assign w_onehot   = NUM_REQ'(1) << w_sel;
    assign w_go       = (r_state == S_IDLE) && !i_Tx_Active && !i_Tx_Done &&
                        (r_lock ? i_Req_Valid[r_ptr] : w_found);
    assign w_lock_to  = (r_state == S_IDLE) && r_lock && !i_Req_Valid[r_ptr] &&
                        (r_lock_tmr == LW'(LOCK_TIMEOUT - 1));
    assign w_start_to = (r_state == S_START) && !i_Tx_Active &&
                        (r_start_tmr == SW'(START_TIMEOUT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_START;
            S_START: begin
                if (i_Tx_Active)     w_next = S_SEND;
                else if (w_start_to) w_next = S_IDLE;
            end
            S_SEND:  if (i_Tx_Done) w_next = S_DRAIN;
            S_DRAIN: if (!i_Tx_Done && !i_Tx_Active) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_ptr       <= PW'(NUM_REQ - 1);
            r_lock      <= 1'b0;
            r_last      <= 1'b0;
            r_start_tmr <= '0;
            r_lock_tmr  <= '0;
            r_ready     <= '0;
            r_grant     <= '0;
            r_dv        <= 1'b0;
            r_err       <= 1'b0;
            r_byte      <= '0;
        end else begin
            r_dv    <= 1'b0;
            r_ready <= '0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_byte      <= i_Req_Data[w_bit +: 8];
                        r_dv        <= 1'b1;
                        r_ready     <= w_onehot;
                        r_grant     <= w_onehot;
                        r_ptr       <= w_sel;
                        r_lock      <= ~i_Req_Last[w_sel];
                        r_last      <= i_Req_Last[w_sel];
                        r_start_tmr <= '0;
                        r_lock_tmr  <= '0;
                    end else if (w_lock_to) begin
                        r_err      <= 1'b1;
                        r_lock     <= 1'b0;
                        r_grant    <= '0;
                        r_lock_tmr <= '0;
                    end else if (r_lock && !i_Req_Valid[r_ptr]) begin
                        r_lock_tmr <= r_lock_tmr + LW'(1);
                    end
                end
                S_START: begin
                    if (w_start_to) begin
                        r_err   <= 1'b1;
                        r_lock  <= 1'b0;
                        r_grant <= '0;
                    end else if (!i_Tx_Active) begin
                        r_start_tmr <= r_start_tmr + SW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!i_Tx_Done && !i_Tx_Active && r_last) begin
                        r_grant <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Req_Ready = r_ready;
    assign o_Grant     = r_grant;
    assign o_Tx_DV     = r_dv;
    assign o_Tx_Byte   = r_byte;
    assign o_Busy      = (r_state != S_IDLE);
    assign o_Err       = r_err;
endmodule
